mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory access port (address, data in, data out, read/write) between two requesters: instruction fetch (read-only) and load/store data access.
- Sits between the fetch/memory stages and the memory instance.
- Arbitrates between the two requesters, sequences one access at a time through a fixed-latency memory, and returns read data or write acknowledges to the requester that was granted.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 1, cycles from the mem_en cycle to mem_data_out being valid. Legal range 1..15.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held high with d_addr/d_wdata/d_rw stable until d_gnt
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rw  in  1  0 = read, 1 = write
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  one-cycle pulse; read data or write done
- d_rdata  out  DATA_W  load data; 0 for writes
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_addr  out  ADDR_W  registered address
- mem_data_in  out  DATA_W  registered write data
- mem_read_write  out  1  registered rw; 0 = read, 1 = write; fetch always 0
- mem_data_out  in  DATA_W  memory read data, valid LATENCY cycles after mem_en

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Grants are asserted only in IDLE.
  - With exactly one requester active, that requester is granted.
  - With both requesters active, round-robin: the requester not granted last wins.
  - last_grant resets to DATA, so fetch wins the first tie.
  - Grant cycle: address, write data, rw and owner are latched; transition to ACCESS.
  - No request: remain in IDLE.
- ACCESS:
  - mem_en = 1 for exactly one cycle, driven with the latched fields.
  - Transition to WAIT if LATENCY > 1, otherwise to RESP.
- WAIT:
  - Counter runs LATENCY-1 cycles with mem_en = 0, then transition to RESP.
- RESP:
  - mem_data_out is captured into the owner's rdata register.
  - The owner's rvalid pulses for one cycle.
  - Writes pulse d_rvalid with d_rdata = 0.
  - Transition to IDLE.
- Timing: grant at cycle T gives mem_en at T+1 and rvalid at T+1+LATENCY. The next grant comes no earlier than T+2+LATENCY.
- One transaction is outstanding at most. A request arriving during ACCESS/WAIT/RESP waits; gnt stays low.
- A requester dropping req before gnt is legal. Nothing is latched and no response is generated.
- The non-granted requester's gnt and rvalid stay 0 for the whole transaction.
- mem_addr, mem_data_in and mem_read_write hold their last values when mem_en = 0.
- Addresses pass through unmodified. There is no alignment check.
- Reset:
  - All outputs go to 0, state goes to IDLE, counter to 0, last_grant to DATA.
  - Reset mid-transaction aborts it: no rvalid is issued and mem_en is 0 from the next cycle.
  - gnt is forced to 0 while reset is high.

Decomposition:
- Shared package pd_mem_pkg:
  - State enum {IDLE, ACCESS, WAIT, RESP}.
  - Owner enum {OWN_FETCH, OWN_DATA}.
  - Constants MEM_READ = 1'b0 and MEM_WRITE = 1'b1.
- Sub-module rr_arb2: two-input round-robin arbiter with a last-grant register. Its update is enabled by the IDLE grant.

Test Plan:
- Single fetch, LATENCY=1: if_req with if_addr=0x01000000 at T; memory returns 0x00500093 -> if_gnt at T, mem_en/mem_addr=0x01000000/mem_read_write=0 at T+1, if_rvalid with if_rdata=0x00500093 at T+2. No d_* activity.
- Data write then read: write d_addr=0x01000010, d_wdata=0xDEADBEEF; then read the same address -> mem_read_write=1 with mem_data_in=0xDEADBEEF; d_rvalid with d_rdata=0 for the write; read returns 0xDEADBEEF.
- Simultaneous requests, held continuously for 4 transactions -> first grant goes to fetch after reset, then grants alternate DATA, FETCH, DATA. No requester is starved.
- LATENCY=3: grant at T -> mem_en only at T+1, rvalid at T+4, next grant no earlier than T+5. A d_req arriving at T+2 sees d_gnt low until IDLE.
- Reset asserted in WAIT (LATENCY=3, cycle T+2) -> no rvalid ever pulses for that transaction, all outputs are 0 the cycle after reset, and the first post-reset tie is granted to fetch.
- Request withdrawn: if_req high for one cycle during RESP, then low -> no grant, no mem_en, no if_rvalid.

Source files
------------

// File: rtl/pd_mem_pkg.sv
// rtl/pd_mem_pkg.sv - shared types and constants for the memory port arbiter
package pd_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with last-grant register
module rr_arb2
    import pd_mem_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic req_fetch,
    input  logic req_data,
    output logic gnt_fetch,
    output logic gnt_data
);

    owner_t last_grant;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        gnt_fetch = 1'b0;
        gnt_data  = 1'b0;
        if (enable) begin
            if (req_fetch && req_data) begin
                if (last_grant == OWN_DATA) begin
                    gnt_fetch = 1'b1;
                end else begin
                    gnt_data = 1'b1;
                end
            end else begin
                gnt_fetch = req_fetch;
                gnt_data  = req_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= OWN_DATA;
        end else if (gnt_fetch) begin
            last_grant <= OWN_FETCH;
        end else if (gnt_data) begin
            last_grant <= OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between fetch and load/store
module mem_port_arbiter
    import pd_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_rw,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_write,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    owner_t            owner;
    logic              arb_en;
    logic              gnt_fetch, gnt_data;
    logic              resp_fetch, resp_data;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    assign arb_en = (state == IDLE) && !reset;

    rr_arb2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .enable    (arb_en),
        .req_fetch (if_req),
        .req_data  (d_req),
        .gnt_fetch (gnt_fetch),
        .gnt_data  (gnt_data)
    );

    assign if_gnt = gnt_fetch;
    assign d_gnt  = gnt_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (gnt_fetch || gnt_data) begin
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                cnt_n   = 4'd0;
                state_n = (LATENCY > 1) ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt == 4'(LATENCY - 2)) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The memory-side registers double as the latched request fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr       <= '0;
            mem_data_in    <= '0;
            mem_read_write <= MEM_READ;
            owner          <= OWN_FETCH;
        end else if (gnt_fetch) begin
            mem_addr       <= if_addr;
            mem_read_write <= MEM_READ;
            owner          <= OWN_FETCH;
        end else if (gnt_data) begin
            mem_addr       <= d_addr;
            mem_data_in    <= d_wdata;
            mem_read_write <= d_rw;
            owner          <= OWN_DATA;
        end
    end

    assign mem_en     = (state == ACCESS) && !reset;
    assign resp_fetch = (state == RESP) && (owner == OWN_FETCH) && !reset;
    assign resp_data  = (state == RESP) && (owner == OWN_DATA) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (resp_fetch) begin
                if_rdata_q <= mem_data_out;
            end
            if (resp_data) begin
                d_rdata_q <= (mem_read_write == MEM_WRITE) ? '0 : mem_data_out;
            end
        end
    end

    // Read data is forwarded in the response cycle and held afterwards.
    assign if_rvalid = resp_fetch;
    assign d_rvalid  = resp_data;
    assign if_rdata  = resp_fetch ? mem_data_out : if_rdata_q;
    assign d_rdata   = resp_data ? ((mem_read_write == MEM_WRITE) ? '0 : mem_data_out) : d_rdata_q;

endmodule
